// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
`timescale 1ns/1ps
package arb_pkg;

    localparam int N_REQ            = 8;
    localparam int ID_W             = 3;
    localparam int HOLD_MAX_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority picker: the lowest set index at or after
// `start` (wrapping mod 8) among the unmasked request bits wins.
`timescale 1ns/1ps
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    input  logic [N_REQ-1:0] mask,
    output logic             hit,
    output logic [ID_W-1:0]  idx
);

    logic [N_REQ-1:0]   eff;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    off;

    // Rotate so `start` sits at bit 0, fixed-priority encode, then rotate back.
    always_comb begin
        eff = req & ~mask;
        dbl = {eff, eff} >> start;
        rot = dbl[N_REQ-1:0];
        hit = |rot;
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        idx = start + off;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with an optional hold-time limit.
// The grant is held until the owner drops its request, or, when HOLD_MAX is
// nonzero, until the owner has held it HOLD_MAX visible cycles while someone
// else is waiting. All outputs are registered; iReq has no combinational path
// to any output.
`timescale 1ns/1ps
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [N_REQ-1:0] iReq,
    output logic [N_REQ-1:0] oGrant,
    output logic [ID_W-1:0]  oGrantId,
    output logic             oBusy,
    output logic             oPreempt
);

    localparam int HOLD_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;

    logic [N_REQ-1:0] owner_onehot;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_hit;
    logic [ID_W-1:0]  pick_idx;
    logic             hold_at_max;

    // While granted, the owner's bit is masked: on release it is already
    // zero, and on preemption the owner must not win its own handoff.
    always_comb begin
        owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
        pick_mask    = (state_q == GRANT) ? owner_onehot : '0;
        hold_at_max  = (HOLD_MAX != 0) && (hold_q == HOLD_LIM);
    end

    rr_pick8 u_pick (
        .req   (iReq),
        .start (ptr_q),
        .mask  (pick_mask),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    // Next-state logic: arbitration, hold counting and output decode.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx + ID_W'(1);
                    hold_d  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (iReq[owner_q]) begin
                    if (hold_at_max && pick_hit) begin
                        owner_d   = pick_idx;
                        ptr_d     = pick_idx + ID_W'(1);
                        hold_d    = HOLD_ONE;
                        preempt_d = 1'b1;
                    end else if ((HOLD_MAX != 0) && (hold_q != HOLD_LIM)) begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end else if (pick_hit) begin
                    owner_d = pick_idx;
                    ptr_d   = pick_idx + ID_W'(1);
                    hold_d  = HOLD_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d    = (state_d == GRANT) ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_d) : '0;
        grant_id_d = (state_d == GRANT) ? owner_d : '0;
        busy_d     = (state_d == GRANT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
        end
    end

    assign oGrant   = grant_q;
    assign oGrantId = grant_id_q;
    assign oBusy    = busy_q;
    assign oPreempt = preempt_q;

endmodule
